// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch from a one-cycle synchronous memory,
// buffered in a DEPTH-entry FIFO and handed to the core under valid/ready, with redirect flush.
module insn_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fpc;
    logic [31:0]   r_req_addr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic          r_inflight;
    logic          r_flush_pend;
    logic          r_err;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic [CW:0]   w_used;
    logic          w_push;
    logic          w_pop;
    logic          w_stray;

    // Credits count the in-flight word so a response always has a free slot.
    assign w_used     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign mem_req    = !rst && !redirect && (w_used < (CW+1)'(DEPTH));
    assign mem_addr   = r_fpc;

    assign insn_valid = !rst && (r_count != '0);
    assign insn       = insn_valid ? r_data[r_head] : '0;
    assign insn_pc    = insn_valid ? r_pc[r_head]   : '0;
    assign resp_err   = r_err;

    assign w_push  = !rst && mem_rvalid && r_inflight && !redirect;
    assign w_pop   = insn_valid && insn_ready;
    // A response right after a redirect is an expected discard, not an error.
    assign w_stray = mem_rvalid && !r_inflight && !r_flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc        <= RESET_PC;
            r_req_addr   <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_flush_pend <= redirect;
            if (w_stray) begin
                r_err <= 1'b1;
            end
            if (redirect) begin
                r_fpc      <= redirect_pc;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= mem_req;
                if (mem_req) begin
                    r_fpc      <= r_fpc + 32'd1;
                    r_req_addr <= r_fpc;
                end
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Slot storage carries no reset; insn_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_tail] <= mem_rdata;
            r_pc[r_tail]   <= r_req_addr;
        end
    end
endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Scoreboard bench: a memory model answers fetches with addr^A5A50000, and the monitor
// checks every delivered word against the expected sequential stream since the last restart.
`timescale 1ns/1ps
module tb_insn_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        resp_err;

    insn_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stream after a restart: sequential words from the new fetch address.
    task automatic restart_expect(input logic [31:0] s);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_t e;
            e.pc = s + 32'(i);
            e.d  = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Memory model: request seen in a cycle is answered in the next; inject forces a stray beat.
    logic        m_req  = 1'b0;
    logic [31:0] m_addr = '0;
    logic        inject = 1'b0;
    always @(negedge clk) begin
        m_req  = mem_req;
        m_addr = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rvalid = m_req || inject;
        mem_rdata  = (inject && !m_req) ? 32'hDEADBEEF : mem_word(m_addr);
        inject     = 1'b0;
    end

    // Monitor: pop and compare on every accepted word.
    always @(negedge clk) begin
        if (!rst && insn_valid && insn_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got pc %h, expected no word", insn_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("insn_pc", insn_pc, e.pc);
                chk("insn", insn, e.d);
                n_pops++;
                $display("pop pc=%h insn=%h", insn_pc, insn);
            end
        end
        if (!insn_valid) begin
            chk("idle_insn", insn, 32'h0);
            chk("idle_insn_pc", insn_pc, 32'h0);
        end
        if (redirect) chk("no_req_in_redirect", 32'(mem_req), 32'h0);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Holds reset for n edges, reseeds the expected stream, releases at start of cycle 0.
    task automatic apply_reset(input int n);
        rst      = 1'b1;
        redirect = 1'b0;
        repeat (n) @(posedge clk);
        restart_expect(RESET_PC);
        #2;
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        cyc();
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        restart_expect(pc);
        #2;
        redirect = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int nreq;
        bit found;
        int since;

        // Reset state and free-run latency.
        insn_ready = 1'b1;
        rst = 1'b1;
        cyc(); #2;
        chk("rst_insn_valid", 32'(insn_valid), 32'h0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        apply_reset(1);
        #2;
        chk("c0_mem_req", 32'(mem_req), 32'h1);
        chk("c0_mem_addr", mem_addr, RESET_PC);
        cyc(); #2;
        chk("c1_insn_valid", 32'(insn_valid), 32'h0);
        cyc(); #2;
        chk("c2_insn_valid", 32'(insn_valid), 32'h1);
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #2;
            if (!insn_valid) gaps++;
        end
        chk("freerun_gaps", 32'(gaps), 32'h0);
        chk("freerun_resp_err", 32'(resp_err), 32'h0);

        // Core stalled: fill to DEPTH, stray beat while full, then drain and resume.
        insn_ready = 1'b0;
        apply_reset(1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            #2;
            if (mem_req) begin
                chk("fill_addr", mem_addr, 32'(nreq));
                nreq++;
            end
            if (i == 7) inject = 1'b1;
        end
        chk("fill_req_count", 32'(nreq), 32'(DEPTH));
        chk("full_resp_err", 32'(resp_err), 32'h1);
        cyc();
        insn_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (k > 0) cyc();
            #2;
            if (mem_req) begin
                found = 1'b1;
                chk("resume_addr", mem_addr, 32'(DEPTH));
            end
        end
        chk("resume_seen", 32'(found), 32'h1);
        repeat (8) cyc();
        chk("sticky_resp_err", 32'(resp_err), 32'h1);

        // Stray beat in cycle 0 right after reset release.
        rst = 1'b1;
        cyc();
        inject = 1'b1;
        apply_reset(1);
        cyc(); #2;
        chk("c0_stray_resp_err", 32'(resp_err), 32'h1);
        apply_reset(1);
        #2;
        chk("reset_clears_err", 32'(resp_err), 32'h0);

        // Redirect while the word for addr 7 is returning.
        apply_reset(1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(); #2;
            if (insn_valid && insn_pc == 32'd5) found = 1'b1;
        end
        chk("saw_pc5", 32'(found), 32'h1);
        do_redirect(32'h100);
        #2;
        chk("redir_mem_req", 32'(mem_req), 32'h1);
        chk("redir_mem_addr", mem_addr, 32'h100);
        cyc(); #2;
        chk("redir_r2_valid", 32'(insn_valid), 32'h0);
        cyc(); #2;
        chk("redir_r3_valid", 32'(insn_valid), 32'h1);
        chk("redir_first_pc", insn_pc, 32'h100);
        repeat (4) cyc();
        chk("redir_resp_err", 32'(resp_err), 32'h0);

        // Fetch pointer wrap.
        do_redirect(32'hFFFFFFFE);
        #2;
        chk("wrap_mem_addr", mem_addr, 32'hFFFFFFFE);
        repeat (8) cyc();

        // Reset mid-stream: 3 queued, addr 3 in flight.
        insn_ready = 1'b0;
        apply_reset(1);
        repeat (4) cyc();
        #2;
        chk("mid_full_req", 32'(mem_req), 32'h0);
        chk("mid_valid", 32'(insn_valid), 32'h1);
        rst = 1'b1;
        cyc(); #2;
        chk("midrst_valid", 32'(insn_valid), 32'h0);
        chk("midrst_insn", insn, 32'h0);
        apply_reset(1);
        #2;
        chk("midrst_req", 32'(mem_req), 32'h1);
        chk("midrst_addr", mem_addr, RESET_PC);
        insn_ready = 1'b1;
        repeat (10) cyc();

        // Randomized traffic with redirects.
        apply_reset(1);
        n_pops = 0;
        since  = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            insn_ready = ($urandom % 4) != 0;
            since++;
            if (($urandom % 40) == 0 || since > 300) begin
                since = 0;
                if ($urandom % 2) do_redirect(32'hFFFFFFF0 + ($urandom % 32));
                else              do_redirect($urandom);
            end
        end
        insn_ready = 1'b1;
        repeat (6) cyc();
        chk("rand_resp_err", 32'(resp_err), 32'h0);
        chk("rand_progress", 32'(n_pops > 1000), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
